// File: rtl/lcd_spi_sink_pkg.sv
// Shared definitions for the LCD SPI sink: command opcodes, decoder state
// encoding and the RGB565 pixel width.
package lcd_spi_sink_pkg;

    // ILI9341-style command opcodes understood by the decoder
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // RGB565 pixel word width
    localparam int RGB565_W = 16;

    // Decoder FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CASET = 3'd1;
    localparam logic [2:0] ST_PASET = 3'd2;
    localparam logic [2:0] ST_RAMWR = 3'd3;
    localparam logic [2:0] ST_SKIP  = 3'd4;

endpackage

// File: rtl/lcd_spi_sink_spi_byte_rx.sv
// spi_byte_rx: oversampling SPI mode-0 byte receiver. Synchronises the five
// line inputs, detects SCLK rising edges and assembles MSB-first bytes.
// o_byte_valid is a one-cycle strobe with no back-pressure; o_byte and
// o_byte_dc are valid in that cycle and hold until the next byte.
module spi_byte_rx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_soft_rst,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_cs,
    input  logic       i_dc,
    input  logic       i_lcd_rst,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_byte_dc,
    output logic       o_cs_rise,
    output logic       o_lcd_rst_n
);

    logic [2:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;
    logic [1:0] r_dc_sync;
    logic [1:0] r_cs_sync;
    logic [1:0] r_lrst_sync;
    logic       r_cs_d;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_byte;
    logic       r_byte_valid;
    logic       r_byte_dc;

    logic       w_sclk_rise;
    logic       w_cs_n;
    logic [7:0] w_next_shift;

    assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_cs_n       = r_cs_sync[1];
    assign w_next_shift = {r_shift[6:0], r_mosi_sync[1]};

    // Two-flop synchronisers; SCLK gets a third stage for edge detection.
    // Idle levels are CS high and panel reset deasserted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk_sync <= 3'b000;
            r_mosi_sync <= 2'b00;
            r_dc_sync   <= 2'b00;
            r_cs_sync   <= 2'b11;
            r_lrst_sync <= 2'b11;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
            r_dc_sync   <= {r_dc_sync[0], i_dc};
            r_cs_sync   <= {r_cs_sync[0], i_cs};
            r_lrst_sync <= {r_lrst_sync[0], i_lcd_rst};
            r_cs_d      <= r_cs_sync[1];
        end
    end

    // Shift MOSI on each SCLK rise while selected; CS high discards a partial byte
    always_ff @(posedge i_clk) begin
        if (i_rst || i_soft_rst) begin
            r_shift      <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_byte_dc    <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_cs_n) begin
                r_bit_cnt <= 3'd0;
            end else if (w_sclk_rise) begin
                r_shift   <= w_next_shift;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte       <= w_next_shift;
                    r_byte_dc    <= r_dc_sync[1];
                    r_byte_valid <= 1'b1;
                end
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;
    assign o_byte_dc    = r_byte_dc;
    assign o_cs_rise    = r_cs_sync[1] & ~r_cs_d;
    assign o_lcd_rst_n  = r_lrst_sync[1];

endmodule

// File: rtl/lcd_spi_sink.sv
// lcd_spi_sink: panel-side receiver for the SPI LCD link. Decodes the
// CASET/PASET/RAMWR command stream into pixel writes with coordinates.
// Optional feature macro: LCD_SPI_SINK_PIXCNT_EN enables the emitted-pixel
// counter on o_pix_count (otherwise tied to 0).
// o_byte_valid and o_pix_valid are one-cycle strobes with no back-pressure:
// the companion data outputs are valid in the strobe cycle and hold until
// the next strobe.
module lcd_spi_sink
    import lcd_spi_sink_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_sclk,
    input  logic                i_mosi,
    input  logic                i_cs,
    input  logic                i_dc,
    input  logic                i_lcd_rst,
    output logic [7:0]          o_byte,
    output logic                o_byte_valid,
    output logic                o_byte_dc,
    output logic [7:0]          o_cmd,
    output logic                o_pix_valid,
    output logic [15:0]         o_pix_x,
    output logic [15:0]         o_pix_y,
    output logic [RGB565_W-1:0] o_pix_data,
    output logic [31:0]         o_pix_count,
    output logic [2:0]          o_dbg_state
);

    logic [7:0]          w_byte;
    logic                w_byte_valid;
    logic                w_byte_dc;
    logic                w_cs_rise;
    logic                w_lcd_rst_n;
    logic                w_soft_rst;
    logic                w_in_range;

    logic [2:0]          r_state;
    logic [7:0]          r_cmd;
    logic [1:0]          r_param_idx;
    logic [7:0]          r_p0;
    logic [7:0]          r_p1;
    logic [7:0]          r_p2;
    logic [15:0]         r_xs;
    logic [15:0]         r_xe;
    logic [15:0]         r_ys;
    logic [15:0]         r_ye;
    logic [15:0]         r_x;
    logic [15:0]         r_y;
    logic [7:0]          r_hi;
    logic                r_hi_have;
    logic                r_pix_valid;
    logic [15:0]         r_pix_x;
    logic [15:0]         r_pix_y;
    logic [RGB565_W-1:0] r_pix_data;

    spi_byte_rx u_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_soft_rst   (w_soft_rst),
        .i_sclk       (i_sclk),
        .i_mosi       (i_mosi),
        .i_cs         (i_cs),
        .i_dc         (i_dc),
        .i_lcd_rst    (i_lcd_rst),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_byte_dc    (w_byte_dc),
        .o_cs_rise    (w_cs_rise),
        .o_lcd_rst_n  (w_lcd_rst_n)
    );

    // Panel reset line behaves like a reset for everything but the pixel counter
    assign w_soft_rst = ~w_lcd_rst_n;
    assign w_in_range = (r_x < 16'(WIDTH)) && (r_y < 16'(HEIGHT));

    // Command decoder, window registers, pixel pointer and pixel output
    always_ff @(posedge i_clk) begin
        if (i_rst || w_soft_rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 8'h00;
            r_param_idx <= 2'd0;
            r_p0        <= 8'h00;
            r_p1        <= 8'h00;
            r_p2        <= 8'h00;
            r_xs        <= 16'd0;
            r_xe        <= 16'(WIDTH - 1);
            r_ys        <= 16'd0;
            r_ye        <= 16'(HEIGHT - 1);
            r_x         <= 16'd0;
            r_y         <= 16'd0;
            r_hi        <= 8'h00;
            r_hi_have   <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_x     <= 16'd0;
            r_pix_y     <= 16'd0;
            r_pix_data  <= '0;
        end else begin
            r_pix_valid <= 1'b0;
            // Deselect between the two halves of a pixel drops the high byte
            if (w_cs_rise) begin
                r_hi_have <= 1'b0;
            end
            if (w_byte_valid) begin
                if (!w_byte_dc) begin
                    r_cmd       <= w_byte;
                    r_param_idx <= 2'd0;
                    case (w_byte)
                        CMD_CASET: r_state <= ST_CASET;
                        CMD_PASET: r_state <= ST_PASET;
                        CMD_RAMWR: begin
                            r_state   <= ST_RAMWR;
                            r_x       <= r_xs;
                            r_y       <= r_ys;
                            r_hi_have <= 1'b0;
                        end
                        default:   r_state <= ST_SKIP;
                    endcase
                end else begin
                    case (r_state)
                        ST_CASET, ST_PASET: begin
                            r_param_idx <= r_param_idx + 2'd1;
                            case (r_param_idx)
                                2'd0:    r_p0 <= w_byte;
                                2'd1:    r_p1 <= w_byte;
                                2'd2:    r_p2 <= w_byte;
                                default: begin
                                    // Window commits atomically on the 4th byte
                                    if (r_state == ST_CASET) begin
                                        r_xs <= {r_p0, r_p1};
                                        r_xe <= {r_p2, w_byte};
                                    end else begin
                                        r_ys <= {r_p0, r_p1};
                                        r_ye <= {r_p2, w_byte};
                                    end
                                    r_state <= ST_IDLE;
                                end
                            endcase
                        end
                        ST_RAMWR: begin
                            if (!r_hi_have) begin
                                r_hi      <= w_byte;
                                r_hi_have <= ~w_cs_rise;
                            end else begin
                                r_hi_have   <= 1'b0;
                                r_pix_valid <= w_in_range;
                                if (w_in_range) begin
                                    r_pix_x    <= r_x;
                                    r_pix_y    <= r_y;
                                    r_pix_data <= {r_hi, w_byte};
                                end
                                // Equality-only compares so inverted windows never lock up
                                if (r_x == r_xe) begin
                                    r_x <= r_xs;
                                    if (r_y == r_ye) begin
                                        r_y <= r_ys;
                                    end else begin
                                        r_y <= r_y + 16'd1;
                                    end
                                end else begin
                                    r_x <= r_x + 16'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef LCD_SPI_SINK_PIXCNT_EN
    logic [31:0] r_pix_count;

    // Emitted-pixel counter survives panel resets; only the system reset clears it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_count <= 32'd0;
        end else if (r_pix_valid) begin
            r_pix_count <= r_pix_count + 32'd1;
        end
    end

    assign o_pix_count = r_pix_count;
`else
    assign o_pix_count = 32'd0;
`endif

    assign o_byte       = w_byte;
    assign o_byte_valid = w_byte_valid;
    assign o_byte_dc    = w_byte_dc;
    assign o_cmd        = r_cmd;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_pix_data   = r_pix_data;
    assign o_dbg_state  = r_state;

endmodule
